// File: rtl/uart_tx.sv
// UART transmitter paired with the 16x-oversampled receiver: start bit, DBIT data bits
// LSB first, optional parity bit, then SB_TICK ticks of stop.
`timescale 1ns/1ps
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PAR_EN  = 0,
  parameter int PAR_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       busy,
  output logic       tx_done_tick,
  output logic       tx
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [4:0] BIT_TICK_LAST = 5'd15;
  localparam logic [4:0] STOP_LAST     = 5'(SB_TICK - 1);
  localparam logic [2:0] BIT_LAST      = 3'(DBIT - 1);
  localparam logic       ODD           = (PAR_ODD != 0);

  state_t     state_q, state_d;
  logic [4:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       tx_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx      <= tx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_d        = par_q;
    tx_done_tick = 1'b0;
    case (state_q)
      IDLE: begin
        // A tick arriving with tx_start is deliberately not counted toward the start bit.
        if (tx_start) begin
          shift_d = din;
          tick_d  = '0;
          bit_d   = '0;
          par_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == BIT_TICK_LAST) begin
            tick_d  = '0;
            state_d = DATA;
          end else tick_d = tick_q + 5'd1;
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_q == BIT_TICK_LAST) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            par_d   = par_q ^ shift_q[0];
            if (bit_q == BIT_LAST) state_d = (PAR_EN != 0) ? PARITY : STOP;
            else                   bit_d   = bit_q + 3'd1;
          end else tick_d = tick_q + 5'd1;
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (tick_q == BIT_TICK_LAST) begin
            tick_d  = '0;
            state_d = STOP;
          end else tick_d = tick_q + 5'd1;
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_q == STOP_LAST) begin
            tick_d       = '0;
            tx_done_tick = 1'b1;
            state_d      = IDLE;
          end else tick_d = tick_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the next state so tx comes straight off a flop.
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d ^ ODD;
      default: tx_d = 1'b1;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter, the transmit-side counterpart of the existing 16x-oversampled UART receiver.
- Serialises a parallel byte into start bit, DBIT data bits (LSB first), optional parity bit and stop period.
- Shares the same s_tick baud generator (16 ticks per bit) as the receiver.
- Sits between the SPI-ADC data path and the host serial link; one byte is accepted per transaction via a start/done handshake.

Parameters:
- DBIT, 8, number of data bits per frame (5..8).
- SB_TICK, 16, s_tick count for the stop period: 16 = 1 stop bit, 24 = 1.5, 32 = 2 (range 16..32).
- PAR_EN, 0, 1 inserts a parity bit after the data bits.
- PAR_ODD, 0, parity sense when PAR_EN=1: 0 = even, 1 = odd.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- s_tick  input  1  one-clk pulse at 16x baud rate.
- tx_start  input  1  request to send din; sampled only in IDLE.
- din  input  8  byte to send; bits [DBIT-1:0] are used.
- busy  output  1  high from acceptance through end of stop period.
- tx_done_tick  output  1  one-clk pulse when the stop period completes.
- tx  output  1  serial line, idle high.

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk.
- Reset values: state=IDLE, tx=1 (registered output), busy=0, tx_done_tick=0, tick counter=0, bit counter=0, shift register=0, parity accumulator=0.
- Reset mid-frame aborts immediately; tx returns to 1 asynchronously.
- Counters: tick counter is 5 bits and counts s_tick pulses only; clk cycles without s_tick leave all state unchanged. Bit counter is 3 bits.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If tx_start=1: latch din into the shift register, clear tick and bit counters, clear parity accumulator, go to START.
  - tx drives 0 from the next clk edge; latency from tx_start to tx falling is 1 clk.
  - busy asserts in the same cycle tx falls.
- START:
  - tx=0.
  - On s_tick with tick=15: tick=0, go to DATA; otherwise tick+1.
- DATA:
  - tx=shift[0].
  - On s_tick with tick=15:
    - tick=0.
    - shift register shifts right by 1.
    - parity accumulator XORs the bit just sent.
    - If bit counter == DBIT-1, go to PARITY if PAR_EN=1, else STOP; otherwise bit counter +1.
  - Otherwise tick+1.
- PARITY:
  - tx = accumulator XOR PAR_ODD.
  - Lasts 16 ticks, then STOP with tick=0.
- STOP:
  - tx=1.
  - On s_tick with tick=SB_TICK-1: tx_done_tick=1 for exactly that clk, go to IDLE.
  - busy deasserts on the following edge.
- Bit timing: each bit is held for exactly 16 s_tick periods; the stop period is held for SB_TICK periods.
- Frame length in ticks = 16·(1+DBIT+PAR_EN) + SB_TICK.
- tx_start while busy=1, including the tx_done_tick cycle, is ignored and not queued.
- tx_start in the first IDLE cycle after done is accepted, giving back-to-back frames with no extra idle bit.
- din is don't-care after acceptance; changes mid-frame do not affect the frame.
- s_tick coincident with tx_start in IDLE is not counted toward the start bit.
- tx is glitch-free (driven from a flop).

Test Plan:
1. Reset asserted mid-DATA -> tx=1, busy=0 asynchronously. After release, tx stays 1 with no tx_done_tick.
2. DBIT=8, PAR_EN=0, din=0x55 with tx_start pulse -> tx sequence 0,1,0,1,0,1,0,1,0,1, each 16 ticks. Stop held 16 ticks. Exactly one tx_done_tick at tick 159. busy high for 160 tick periods.
3. PAR_EN=1, PAR_ODD=0, din=0x07 -> parity bit 1. With PAR_ODD=1 -> parity bit 0. Frame is 176 ticks.
4. tx_start re-pulsed with din=0xFF during DATA of a 0x00 frame -> ignored. Received byte is 0x00; only one tx_done_tick.
5. tx_start held high continuously with din=0xA3 -> back-to-back frames. Start bit begins 1 clk after each tx_done_tick; no tx_start is accepted in the done cycle.
6. SB_TICK=32, DBIT=7, din=0xC1 -> 7 bits sent (1,0,0,0,0,0,1). Stop held 32 ticks. Loopback into the receiver with matching parameters yields 0x41 with rx_done_tick.
